// File: rtl/trap_pkg.sv
// Cause codes, mstatus field positions and FSM state type shared by the
// machine-mode trap controller and its interrupt arbiter.
package trap_pkg;

    localparam int IRQ_MSI     = 3;
    localparam int IRQ_MTI     = 7;
    localparam int IRQ_MEI     = 11;

    localparam int EXC_ILL     = 2;
    localparam int EXC_BRK     = 3;
    localparam int EXC_ECALL_M = 11;
    localparam int EXC_LD_MIS  = 4;
    localparam int EXC_ST_MIS  = 6;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] M_MODE = 2'b11;
    localparam logic [1:0] U_MODE = 2'b00;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WFI      = 2'd1,
        REDIRECT = 2'd2
    } trap_state_e;

endpackage

// File: rtl/irq_arb.sv
// Fixed-priority interrupt picker over the enabled-and-pending vector:
// MEI > MSI > MTI > platform-local IRQs (highest index first).
module irq_arb
    import trap_pkg::*;
#(
    parameter int IRQ_W = 32
)(
    input  logic [IRQ_W-1:0] pend,
    output logic             valid,
    output logic [5:0]       code
);

    // Standard bits that have no meaning in machine-only mode never win.
    logic unused_pend;
    assign unused_pend = ^{pend[15:12], pend[10:8], pend[6:4], pend[2:0]};

    always_comb begin
        valid = 1'b0;
        code  = '0;
        // Ascending scan: the highest local index is the last one written.
        for (int i = 16; i < IRQ_W; i++) begin
            if (pend[i]) begin
                valid = 1'b1;
                code  = 6'(i);
            end
        end
        if (pend[IRQ_MTI]) begin
            valid = 1'b1;
            code  = 6'(IRQ_MTI);
        end
        if (pend[IRQ_MSI]) begin
            valid = 1'b1;
            code  = 6'(IRQ_MSI);
        end
        if (pend[IRQ_MEI]) begin
            valid = 1'b1;
            code  = 6'(IRQ_MEI);
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt controller at write-back: arbitrates traps at
// commit, produces CSR updates and owns the BRU redirect and WFI sleep.
//
//   state    | meaning
//   IDLE     | commits flow; traps, mret and wfi are decoded here
//   WFI      | sleeping after wfi; wakes on any enabled pending bit
//   REDIRECT | target held on o_iru_pc until the BRU accepts it
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int CPU_WIDTH   = 64,
    parameter int IRQ_W       = 32,
    parameter bit VECTORED_EN = 1'b1
)(
    input  logic                 i_clk,
    input  logic                 i_rst_n,

    input  logic                 i_wbu_valid,
    input  logic                 i_wbu_ready,
    input  logic                 i_wbu_nop,
    input  logic [CPU_WIDTH-1:0] i_wbu_pc,
    input  logic                 i_wbu_ecall,
    input  logic                 i_wbu_ebreak,
    input  logic                 i_wbu_mret,
    input  logic                 i_wbu_wfi,
    input  logic                 i_wbu_illegal,
    input  logic                 i_wbu_ld_misalign,
    input  logic                 i_wbu_st_misalign,
    input  logic [31:0]          i_wbu_inst,
    input  logic [CPU_WIDTH-1:0] i_wbu_badaddr,

    output logic                 o_iru_hold,
    output logic                 o_iru_redirect_valid,
    input  logic                 i_iru_redirect_ready,
    output logic [CPU_WIDTH-1:0] o_iru_pc,
    output logic                 o_iru_excp,
    output logic                 o_iru_intr,

    input  logic [CPU_WIDTH-1:0] i_mie,
    input  logic [CPU_WIDTH-1:0] i_mip,
    input  logic [CPU_WIDTH-1:0] i_mtvec,
    input  logic [CPU_WIDTH-1:0] i_mepc,
    input  logic [CPU_WIDTH-1:0] i_mstatus,

    output logic                 o_mepc_wen,
    output logic                 o_mcause_wen,
    output logic                 o_mtval_wen,
    output logic                 o_mstatus_wen,
    output logic [CPU_WIDTH-1:0] o_mepc_wdata,
    output logic [CPU_WIDTH-1:0] o_mcause_wdata,
    output logic [CPU_WIDTH-1:0] o_mtval_wdata,
    output logic [CPU_WIDTH-1:0] o_mstatus_wdata
);

    trap_state_e          state, state_nxt;
    logic [IRQ_W-1:0]     pend;
    logic                 irq_valid;
    logic [5:0]           irq_code;
    logic                 commit;
    logic                 mie_on;
    logic                 exc_any;
    logic                 irq_take, exc_take, mret_take, wfi_take, wake_plain;
    logic [5:0]           exc_code;
    logic [CPU_WIDTH-1:0] exc_tval;
    logic [CPU_WIDTH-1:0] epc;
    logic [CPU_WIDTH-1:0] base;
    logic [CPU_WIDTH-1:0] vec_off;
    logic [CPU_WIDTH-1:0] target;
    logic [CPU_WIDTH-1:0] mstatus_trap, mstatus_mret;
    logic [CPU_WIDTH-1:0] wfi_pc;
    logic [CPU_WIDTH-1:0] pc_q;
    logic                 excp_q, intr_q;

    assign pend = i_mip[IRQ_W-1:0] & i_mie[IRQ_W-1:0];

    generate
        if (IRQ_W < CPU_WIDTH) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^{i_mip[CPU_WIDTH-1:IRQ_W], i_mie[CPU_WIDTH-1:IRQ_W]};
        end
    endgenerate

    irq_arb #(
        .IRQ_W (IRQ_W)
    ) u_irq_arb (
        .pend  (pend),
        .valid (irq_valid),
        .code  (irq_code)
    );

    // Gated by reset so no CSR write can leak out while reset is held.
    assign commit  = i_rst_n & i_wbu_valid & i_wbu_ready & ~i_wbu_nop & (state == IDLE);
    assign mie_on  = i_mstatus[MSTATUS_MIE];
    assign exc_any = i_wbu_illegal | i_wbu_ebreak | i_wbu_ecall
                   | i_wbu_ld_misalign | i_wbu_st_misalign;

    always_comb begin
        exc_code = '0;
        exc_tval = '0;
        if (i_wbu_illegal) begin
            exc_code = 6'(EXC_ILL);
            exc_tval = {{(CPU_WIDTH-32){1'b0}}, i_wbu_inst};
        end else if (i_wbu_ebreak) begin
            exc_code = 6'(EXC_BRK);
            exc_tval = i_wbu_pc;
        end else if (i_wbu_ecall) begin
            exc_code = 6'(EXC_ECALL_M);
        end else if (i_wbu_ld_misalign) begin
            exc_code = 6'(EXC_LD_MIS);
            exc_tval = i_wbu_badaddr;
        end else if (i_wbu_st_misalign) begin
            exc_code = 6'(EXC_ST_MIS);
            exc_tval = i_wbu_badaddr;
        end
    end

    // Event decode: an interrupt discards whatever instruction is committing.
    always_comb begin
        irq_take   = 1'b0;
        exc_take   = 1'b0;
        mret_take  = 1'b0;
        wfi_take   = 1'b0;
        wake_plain = 1'b0;
        epc        = i_wbu_pc;
        if (state == WFI) begin
            epc = wfi_pc;
            if (|pend) begin
                if (mie_on && irq_valid) irq_take   = 1'b1;
                else                     wake_plain = 1'b1;
            end
        end else if (commit) begin
            if (mie_on && irq_valid) irq_take  = 1'b1;
            else if (exc_any)        exc_take  = 1'b1;
            else if (i_wbu_mret)     mret_take = 1'b1;
            else if (i_wbu_wfi)      wfi_take  = 1'b1;
        end
    end

    always_comb begin
        base    = {i_mtvec[CPU_WIDTH-1:2], 2'b00};
        vec_off = {{(CPU_WIDTH-8){1'b0}}, irq_code, 2'b00};
        if (irq_take && VECTORED_EN && (i_mtvec[1:0] == MTVEC_VECTORED))
            target = base + vec_off;
        else if (irq_take || exc_take)
            target = base;
        else if (mret_take)
            target = i_mepc;
        else
            target = wfi_pc;
    end

    always_comb begin
        mstatus_trap                                = i_mstatus;
        mstatus_trap[MSTATUS_MPIE]                  = i_mstatus[MSTATUS_MIE];
        mstatus_trap[MSTATUS_MIE]                   = 1'b0;
        mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = M_MODE;

        mstatus_mret                                = i_mstatus;
        mstatus_mret[MSTATUS_MIE]                   = i_mstatus[MSTATUS_MPIE];
        mstatus_mret[MSTATUS_MPIE]                  = 1'b1;
        mstatus_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = U_MODE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (irq_take || exc_take || mret_take) state_nxt = REDIRECT;
                else if (wfi_take)                      state_nxt = WFI;
            end
            WFI: begin
                if (irq_take || wake_plain) state_nxt = REDIRECT;
            end
            REDIRECT: begin
                if (i_iru_redirect_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_iru_hold           = (state != IDLE);
        o_iru_redirect_valid = (state == REDIRECT);
        o_iru_pc             = pc_q;
        o_iru_excp           = excp_q;
        o_iru_intr           = intr_q;

        o_mepc_wen      = irq_take | exc_take;
        o_mcause_wen    = irq_take | exc_take;
        o_mtval_wen     = irq_take | exc_take;
        o_mstatus_wen   = irq_take | exc_take | mret_take;
        o_mepc_wdata    = epc;
        o_mcause_wdata  = {irq_take, {(CPU_WIDTH-7){1'b0}}, (irq_take ? irq_code : exc_code)};
        o_mtval_wdata   = irq_take ? '0 : exc_tval;
        o_mstatus_wdata = mret_take ? mstatus_mret : mstatus_trap;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q   <= '0;
            excp_q <= 1'b0;
            intr_q <= 1'b0;
            wfi_pc <= '0;
        end else begin
            if (irq_take || exc_take || mret_take || wake_plain) begin
                pc_q   <= target;
                excp_q <= exc_take | mret_take;
                intr_q <= irq_take;
            end else if ((state == REDIRECT) && i_iru_redirect_ready) begin
                excp_q <= 1'b0;
                intr_q <= 1'b0;
            end
            if (wfi_take)
                wfi_pc <= i_wbu_pc + {{(CPU_WIDTH-3){1'b0}}, 3'd4};
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a driver runs a behavioural trap model and
// queues expected responses; a negedge monitor compares what the DUT shows.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_wbu_valid, i_wbu_ready, i_wbu_nop;
    logic [63:0] i_wbu_pc;
    logic        i_wbu_ecall, i_wbu_ebreak, i_wbu_mret, i_wbu_wfi;
    logic        i_wbu_illegal, i_wbu_ld_misalign, i_wbu_st_misalign;
    logic [31:0] i_wbu_inst;
    logic [63:0] i_wbu_badaddr;
    logic        o_iru_hold, o_iru_redirect_valid, i_iru_redirect_ready;
    logic [63:0] o_iru_pc;
    logic        o_iru_excp, o_iru_intr;
    logic [63:0] i_mie, i_mip, i_mtvec, i_mepc, i_mstatus;
    logic        o_mepc_wen, o_mcause_wen, o_mtval_wen, o_mstatus_wen;
    logic [63:0] o_mepc_wdata, o_mcause_wdata, o_mtval_wdata, o_mstatus_wdata;

    trap_ctrl #(
        .CPU_WIDTH   (64),
        .IRQ_W       (32),
        .VECTORED_EN (1'b1)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_wbu_valid          (i_wbu_valid),
        .i_wbu_ready          (i_wbu_ready),
        .i_wbu_nop            (i_wbu_nop),
        .i_wbu_pc             (i_wbu_pc),
        .i_wbu_ecall          (i_wbu_ecall),
        .i_wbu_ebreak         (i_wbu_ebreak),
        .i_wbu_mret           (i_wbu_mret),
        .i_wbu_wfi            (i_wbu_wfi),
        .i_wbu_illegal        (i_wbu_illegal),
        .i_wbu_ld_misalign    (i_wbu_ld_misalign),
        .i_wbu_st_misalign    (i_wbu_st_misalign),
        .i_wbu_inst           (i_wbu_inst),
        .i_wbu_badaddr        (i_wbu_badaddr),
        .o_iru_hold           (o_iru_hold),
        .o_iru_redirect_valid (o_iru_redirect_valid),
        .i_iru_redirect_ready (i_iru_redirect_ready),
        .o_iru_pc             (o_iru_pc),
        .o_iru_excp           (o_iru_excp),
        .o_iru_intr           (o_iru_intr),
        .i_mie                (i_mie),
        .i_mip                (i_mip),
        .i_mtvec              (i_mtvec),
        .i_mepc               (i_mepc),
        .i_mstatus            (i_mstatus),
        .o_mepc_wen           (o_mepc_wen),
        .o_mcause_wen         (o_mcause_wen),
        .o_mtval_wen          (o_mtval_wen),
        .o_mstatus_wen        (o_mstatus_wen),
        .o_mepc_wdata         (o_mepc_wdata),
        .o_mcause_wdata       (o_mcause_wdata),
        .o_mtval_wdata        (o_mtval_wdata),
        .o_mstatus_wdata      (o_mstatus_wdata)
    );

    typedef struct packed {
        logic        valid, wready, nop;
        logic        ecall, ebreak, mret, wfi, ill, ldm, stm;
        logic [63:0] pc, badaddr, mie, mip, mtvec, mepc, mstatus;
        logic [31:0] inst;
        logic        rready;
    } stim_t;

    typedef struct packed {
        logic [3:0]  wen;      // {mepc, mcause, mtval, mstatus}
        logic [63:0] mepc, mcause, mtval, mstatus;
        logic [31:0] cyc;
    } csr_t;

    typedef struct packed {
        logic [63:0] pc;
        logic        excp, intr;
    } rd_t;

    typedef struct packed {
        logic hold, rv;
    } cyc_t;

    csr_t csr_q[$];
    rd_t  rd_q[$];
    cyc_t cyc_q[$];

    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          mode = 0;          // 0 running, 1 asleep, 2 redirect pending
    logic [63:0] wfi_pc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int pick(input logic [63:0] mip, input logic [63:0] mie);
        logic [31:0] p;
        p = mip[31:0] & mie[31:0];
        if (p[11]) return 11;
        if (p[3])  return 3;
        if (p[7])  return 7;
        for (int i = 31; i >= 16; i--) if (p[i]) return i;
        return -1;
    endfunction

    function automatic logic [63:0] vec_target(input logic [63:0] mtvec, input bit intr, input int code);
        logic [63:0] base;
        base = mtvec & ~64'h3;
        if (intr && mtvec[1:0] == 2'b01) return base + 64'(code * 4);
        return base;
    endfunction

    function automatic stim_t base_stim();
        stim_t s;
        s = '0;
        s.wready = 1'b1;
        s.rready = 1'b1;
        s.mtvec  = 64'h200;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        i_wbu_valid          = s.valid;
        i_wbu_ready          = s.wready;
        i_wbu_nop            = s.nop;
        i_wbu_pc             = s.pc;
        i_wbu_ecall          = s.ecall;
        i_wbu_ebreak         = s.ebreak;
        i_wbu_mret           = s.mret;
        i_wbu_wfi            = s.wfi;
        i_wbu_illegal        = s.ill;
        i_wbu_ld_misalign    = s.ldm;
        i_wbu_st_misalign    = s.stm;
        i_wbu_inst           = s.inst;
        i_wbu_badaddr        = s.badaddr;
        i_iru_redirect_ready = s.rready;
        i_mie                = s.mie;
        i_mip                = s.mip;
        i_mtvec              = s.mtvec;
        i_mepc               = s.mepc;
        i_mstatus            = s.mstatus;
    endtask

    task automatic take_trap(input stim_t s, input bit intr, input int code,
                             input logic [63:0] epc, input logic [63:0] tval);
        csr_t c;
        rd_t  r;
        c.wen     = 4'b1111;
        c.mepc    = epc;
        c.mcause  = (intr ? 64'h8000_0000_0000_0000 : 64'h0) + 64'(code);
        c.mtval   = tval;
        c.mstatus = s.mstatus;
        c.mstatus[7]     = s.mstatus[3];
        c.mstatus[3]     = 1'b0;
        c.mstatus[12:11] = 2'b11;
        c.cyc     = 32'(cyc);
        csr_q.push_back(c);
        r.pc   = vec_target(s.mtvec, intr, code);
        r.excp = !intr;
        r.intr = intr;
        rd_q.push_back(r);
        mode = 2;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic drive(input stim_t s);
        cyc_t ce;
        csr_t c;
        rd_t  r;
        int   irq;
        apply(s);
        ce.hold = (mode != 0);
        ce.rv   = (mode == 2);
        cyc_q.push_back(ce);
        irq = pick(s.mip, s.mie);
        if (mode == 0) begin
            if (s.valid && s.wready && !s.nop) begin
                if (s.mstatus[3] && irq >= 0) take_trap(s, 1'b1, irq, s.pc, 64'h0);
                else if (s.ill)    take_trap(s, 1'b0, 2,  s.pc, {32'h0, s.inst});
                else if (s.ebreak) take_trap(s, 1'b0, 3,  s.pc, s.pc);
                else if (s.ecall)  take_trap(s, 1'b0, 11, s.pc, 64'h0);
                else if (s.ldm)    take_trap(s, 1'b0, 4,  s.pc, s.badaddr);
                else if (s.stm)    take_trap(s, 1'b0, 6,  s.pc, s.badaddr);
                else if (s.mret) begin
                    c = '0;
                    c.wen     = 4'b0001;
                    c.mstatus = s.mstatus;
                    c.mstatus[3]     = s.mstatus[7];
                    c.mstatus[7]     = 1'b1;
                    c.mstatus[12:11] = 2'b00;
                    c.cyc     = 32'(cyc);
                    csr_q.push_back(c);
                    r.pc = s.mepc; r.excp = 1'b1; r.intr = 1'b0;
                    rd_q.push_back(r);
                    mode = 2;
                end else if (s.wfi) begin
                    wfi_pc = s.pc + 64'd4;
                    mode   = 1;
                end
            end
        end else if (mode == 1) begin
            if (|(s.mip[31:0] & s.mie[31:0])) begin
                if (s.mstatus[3] && irq >= 0) take_trap(s, 1'b1, irq, wfi_pc, 64'h0);
                else begin
                    r.pc = wfi_pc; r.excp = 1'b0; r.intr = 1'b0;
                    rd_q.push_back(r);
                    mode = 2;
                end
            end
        end else if (s.rready) begin
            mode = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        stim_t s;
        for (int i = 0; i < 10 && mode != 0; i++) begin
            s = base_stim();
            if (mode == 1) begin
                s.mip = 64'h8;
                s.mie = 64'h8;
            end
            drive(s);
        end
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s = '0;
        s.valid  = ($urandom_range(0, 3) != 0);
        s.wready = ($urandom_range(0, 4) != 0);
        s.nop    = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 10))
            0: s.ecall  = 1'b1;
            1: s.ebreak = 1'b1;
            2: s.ill    = 1'b1;
            3: s.ldm    = 1'b1;
            4: s.stm    = 1'b1;
            5: s.mret   = 1'b1;
            6, 7: s.wfi = 1'b1;
            8: begin
                s.ill    = 1'($urandom_range(0, 1));
                s.ebreak = 1'($urandom_range(0, 1));
                s.ecall  = 1'($urandom_range(0, 1));
                s.ldm    = 1'($urandom_range(0, 1));
                s.stm    = 1'($urandom_range(0, 1));
            end
            default: ;
        endcase
        s.pc      = {$urandom, $urandom};
        if ($urandom_range(0, 15) == 0) s.pc = 64'hFFFF_FFFF_FFFF_FFFC;
        s.inst    = $urandom;
        s.badaddr = {$urandom, $urandom};
        s.mepc    = {$urandom, $urandom};
        s.mstatus = {$urandom, $urandom};
        s.mtvec   = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) s.mtvec[1:0] = 2'b01;
        if ($urandom_range(0, 15) == 0) s.mtvec = 64'hFFFF_FFFF_FFFF_FFFD;
        s.mip = {$urandom, 32'h0};
        if ($urandom_range(0, 3) == 0) s.mip[rand_bit()] = 1'b1;
        if ($urandom_range(0, 7) == 0) s.mip[rand_bit()] = 1'b1;
        if ($urandom_range(0, 7) == 0) s.mip = s.mip | {32'h0, $urandom & 32'h0000_F777};
        s.mie    = ($urandom_range(0, 1) != 0) ? '1 : {$urandom, $urandom};
        s.rready = ($urandom_range(0, 2) != 0);
        return s;
    endfunction

    function automatic int rand_bit();
        int k;
        k = $urandom_range(0, 18);
        if (k == 0) return 3;
        if (k == 1) return 7;
        if (k == 2) return 11;
        return k + 13;
    endfunction

    // Monitor
    cyc_t       m_ce;
    csr_t       m_c;
    logic [3:0] m_w;

    initial begin
        forever begin
            @(negedge clk);
            if (cyc_q.size() != 0) begin
                m_ce = cyc_q.pop_front();
                chk("hold", 64'(o_iru_hold), 64'(m_ce.hold));
                chk("redirect_valid", 64'(o_iru_redirect_valid), 64'(m_ce.rv));
                m_w = {o_mepc_wen, o_mcause_wen, o_mtval_wen, o_mstatus_wen};
                if (csr_q.size() != 0 && csr_q[0].cyc == 32'(cyc)) begin
                    m_c = csr_q.pop_front();
                    chk("csr_wen", 64'(m_w), 64'(m_c.wen));
                    if (m_c.wen[3]) chk("mepc", o_mepc_wdata, m_c.mepc);
                    if (m_c.wen[2]) chk("mcause", o_mcause_wdata, m_c.mcause);
                    if (m_c.wen[1]) chk("mtval", o_mtval_wdata, m_c.mtval);
                    if (m_c.wen[0]) chk("mstatus", o_mstatus_wdata, m_c.mstatus);
                end else begin
                    chk("csr_wen_quiet", 64'(m_w), 64'h0);
                end
                if (o_iru_redirect_valid) begin
                    if (rd_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL redirect_unexpected: got valid with pc 0x%0h, expected no redirect (cycle %0d)",
                                 o_iru_pc, cyc);
                    end else begin
                        chk("redirect_pc", o_iru_pc, rd_q[0].pc);
                        chk("redirect_excp", 64'(o_iru_excp), 64'(rd_q[0].excp));
                        chk("redirect_intr", 64'(o_iru_intr), 64'(rd_q[0].intr));
                        if (i_iru_redirect_ready) void'(rd_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        stim_t s;

        // Reset with a live ecall commit on the inputs: nothing may escape.
        s = base_stim();
        s.valid = 1'b1;
        s.ecall = 1'b1;
        apply(s);
        #22;
        chk("reset_hold", 64'(o_iru_hold), 64'h0);
        chk("reset_rv", 64'(o_iru_redirect_valid), 64'h0);
        chk("reset_pc", o_iru_pc, 64'h0);
        chk("reset_excp", 64'(o_iru_excp), 64'h0);
        chk("reset_intr", 64'(o_iru_intr), 64'h0);
        chk("reset_wen", 64'({o_mepc_wen, o_mcause_wen, o_mtval_wen, o_mstatus_wen}), 64'h0);
        apply(base_stim());
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Timer IRQ, vectored mtvec.
        s = base_stim();
        s.valid = 1'b1; s.pc = 64'h8000_0100; s.mstatus = 64'h8;
        s.mie = 64'h80; s.mip = 64'h80; s.mtvec = 64'h8000_0001;
        drive(s);
        drive(base_stim());

        // MEI + MTI + ecall on the same commit.
        s = base_stim();
        s.valid = 1'b1; s.ecall = 1'b1; s.pc = 64'h1000; s.mstatus = 64'h8;
        s.mie = 64'h880; s.mip = 64'h880;
        drive(s);
        drive(base_stim());

        // Illegal instruction.
        s = base_stim();
        s.valid = 1'b1; s.ill = 1'b1; s.pc = 64'h100; s.inst = 32'hFFFF_FFFF;
        drive(s);
        drive(base_stim());

        // WFI with MIE=0, then MIE=1.
        for (int pass = 0; pass < 2; pass++) begin
            s = base_stim();
            s.valid = 1'b1; s.wfi = 1'b1; s.pc = 64'h400;
            drive(s);
            for (int i = 0; i < 5; i++) drive(base_stim());
            s = base_stim();
            s.mip = 64'h8; s.mie = 64'h8; s.mstatus = (pass == 0) ? 64'h0 : 64'h8;
            drive(s);
            drive(base_stim());
        end

        // mret under backpressure, commits offered while the redirect waits.
        s = base_stim();
        s.valid = 1'b1; s.mret = 1'b1; s.mepc = 64'h3000; s.mstatus = 64'h80;
        drive(s);
        for (int i = 0; i < 4; i++) begin
            s = base_stim();
            s.valid = 1'b1; s.ecall = 1'b1; s.pc = 64'h5000; s.rready = 1'b0;
            drive(s);
        end
        s = base_stim();
        s.valid = 1'b1; s.ecall = 1'b1; s.pc = 64'h5000;
        drive(s);
        s.pc = 64'h6000;
        drive(s);
        drive(base_stim());

        // Async reset while a redirect is pending.
        s = base_stim();
        s.valid = 1'b1; s.mret = 1'b1; s.mepc = 64'h7000;
        drive(s);
        s = base_stim();
        s.valid = 1'b1; s.ecall = 1'b1; s.rready = 1'b0;
        drive(s);
        apply(s);
        rst_n = 1'b0;
        cyc_q.delete();
        csr_q.delete();
        rd_q.delete();
        mode = 0;
        #1;
        chk("midrst_rv", 64'(o_iru_redirect_valid), 64'h0);
        chk("midrst_hold", 64'(o_iru_hold), 64'h0);
        chk("midrst_pc", o_iru_pc, 64'h0);
        chk("midrst_wen", 64'({o_mepc_wen, o_mcause_wen, o_mtval_wen, o_mstatus_wen}), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s = base_stim();
        s.valid = 1'b1; s.ebreak = 1'b1; s.pc = 64'h9000;
        drive(s);
        drive(base_stim());

        for (int i = 0; i < 3000; i++) drive(rand_stim());
        drain();
        drive(base_stim());

        chk("csr_queue_empty", 64'(csr_q.size()), 64'h0);
        chk("redirect_queue_empty", 64'(rd_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Parametrised machine-mode trap/interrupt controller at the write-back stage.
- Arbitrates multiple interrupt sources and synchronous exceptions at instruction commit, and updates mepc/mcause/mtval/mstatus.
- Owns a redirect handshake to the BRU and a WFI sleep state, replacing the purely combinational trap logic used so far.

Parameters:
- CPU_WIDTH, 64, datapath/CSR width.
- IRQ_W, 32, number of mip/mie bits arbitrated; bits >=16 are platform-local IRQs.
- VECTORED_EN, 1, honour mtvec.MODE==1 (vectored) for interrupts; 0 forces direct mode.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wbu_valid / i_wbu_ready / i_wbu_nop  in  1  WBU handshake and bubble flag
- i_wbu_pc  in  CPU_WIDTH  committing PC
- i_wbu_ecall / i_wbu_ebreak / i_wbu_mret / i_wbu_wfi / i_wbu_illegal / i_wbu_ld_misalign / i_wbu_st_misalign  in  1  instruction class flags
- i_wbu_inst  in  32  raw instruction (illegal mtval)
- i_wbu_badaddr  in  CPU_WIDTH  misaligned effective address
- o_iru_hold  out  1  WBU must not commit while high
- o_iru_redirect_valid  out  1  redirect request to BRU
- i_iru_redirect_ready  in  1  BRU accepts redirect
- o_iru_pc  out  CPU_WIDTH  redirect target (registered)
- o_iru_excp / o_iru_intr  out  1  registered class of pending redirect
- i_mie / i_mip / i_mtvec / i_mepc / i_mstatus  in  CPU_WIDTH  CSR read values
- o_mepc_wen, o_mcause_wen, o_mtval_wen, o_mstatus_wen  out  1  CSR write enables
- o_mepc_wdata, o_mcause_wdata, o_mtval_wdata, o_mstatus_wdata  out  CPU_WIDTH  CSR write data

Behaviour:
- Reset: state IDLE; o_iru_redirect_valid, o_iru_excp, o_iru_intr, all *_wen = 0; o_iru_pc = 0; o_iru_hold = 0.
- commit = i_wbu_valid & i_wbu_ready & !i_wbu_nop & state==IDLE.
- Interrupt arbitration:
  - Candidate set: pend = i_mip & i_mie, bits [IRQ_W-1:0].
  - Taken only if i_mstatus.MIE, except on WFI wake (see below).
  - Priority: 11 (MEI) > 3 (MSI) > 7 (MTI) > local bits 16..IRQ_W-1, highest index first. All other bits are ignored.
- Exception priority: illegal (2) > ebreak (3) > ecall (11) > ld_misalign (4) > st_misalign (6).
- Interrupt beats any exception, mret or wfi on the same commit. The instruction is discarded and mepc = i_wbu_pc.
- Trap on commit (same cycle, combinational wen):
  - mepc = i_wbu_pc.
  - mcause = {intr, zeros, code}.
  - mtval = i_wbu_inst zero-extended (illegal), i_wbu_badaddr (misaligned), i_wbu_pc (ebreak), else 0.
  - mstatus: MPIE <= MIE, MIE <= 0, MPP <= 2'b11.
  - Next cycle: state REDIRECT, o_iru_excp/o_iru_intr set.
- Trap target:
  - base = {mtvec[CPU_WIDTH-1:2], 2'b00}.
  - If VECTORED_EN, mtvec[1:0]==1 and interrupt: base + (code<<2); otherwise base.
- mret commit:
  - mstatus: MIE <= MPIE, MPIE <= 1, MPP <= 2'b00.
  - Target i_mepc; o_iru_excp = 1; go REDIRECT.
- wfi commit with no interrupt: no CSR write; latch pc+4; go WFI.
- WFI state:
  - o_iru_hold = 1.
  - Exit when |pend, regardless of MIE.
  - If MIE = 1: take the highest-priority interrupt with mepc = latched pc+4 (CSR writes in the exit cycle).
  - Else: redirect to latched pc+4 with no CSR write.
  - Either way, go to REDIRECT.
- REDIRECT state:
  - o_iru_redirect_valid = 1 and o_iru_hold = 1.
  - o_iru_pc and flags stable until i_iru_redirect_ready; then return to IDLE next cycle.
  - Minimum turnaround is trap at cycle N, valid N+1, ready N+1, IDLE N+2, next commit N+2.
- Holding commits in REDIRECT guarantees the CSR file's updated MIE is visible before the next arbitration.
- No trap and no mret/wfi: pass-through, no outputs asserted.
- Reset asserted in any state: immediately IDLE with all outputs at reset values. Pending redirects are dropped.
- Width: PC+4 and vector add wrap modulo 2^CPU_WIDTH.

Decomposition:
- Package trap_pkg:
  - Cause codes: IRQ_MSI=3, IRQ_MTI=7, IRQ_MEI=11, EXC_ILL=2, EXC_BRK=3, EXC_ECALL_M=11, EXC_LD_MIS=4, EXC_ST_MIS=6.
  - mstatus bit indices (MIE=3, MPIE=7, MPP=12:11), M_MODE=2'b11.
  - mtvec mode constants and state enum {IDLE, WFI, REDIRECT}.
- Sub-module irq_arb (parameter IRQ_W): combinational priority encoder, pend -> valid + 6-bit code.

Test Plan:
- Timer IRQ: mstatus.MIE=1, mie=mip=0x80, commit pc=0x8000_0100, mtvec=0x8000_0001 -> mcause=0x8000_0000_0000_0007, mepc=0x8000_0100, target 0x8000_001C, redirect_valid next cycle.
- Simultaneous MEI+MTI+ecall: mip=mie=0x880, MIE=1 -> mcause code 11 with interrupt bit set, ecall ignored, mstatus.MIE=0, MPIE=1.
- Illegal instruction: inst 0xFFFF_FFFF at pc 0x100, mtvec=0x200 -> mcause=2, mtval=0xFFFF_FFFF, target 0x200.
- WFI with MIE=0: wfi at 0x400, mip.MSIP rises 5 cycles later -> hold high 5 cycles, redirect to 0x404, no CSR writes. Repeat with MIE=1 -> mepc=0x404, mcause code 3.
- Backpressure: keep i_iru_redirect_ready low 4 cycles after mret (mepc=0x3000) -> o_iru_pc=0x3000 stable, hold=1, no commit accepted until the cycle after ready.
- Async reset asserted mid-REDIRECT -> redirect_valid drops in the same cycle, state IDLE after release.
